// File: rtl/uart_pkg.sv
// Shared definitions for the UART blocks: FSM state codes, parity modes and
// the bit-period calculation.
package uart_pkg;

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StStart  = 3'd1;
  localparam logic [2:0] StData   = 3'd2;
  localparam logic [2:0] StParity = 3'd3;
  localparam logic [2:0] StStop   = 3'd4;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_ODD  = 1;
  localparam int unsigned PAR_EVEN = 2;

  function automatic int unsigned clks_per_bit(input int unsigned clk_hz,
                                                input int unsigned baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter with synchronous clear; flags the half-bit and full-bit
// points so a receiver can sample at mid-bit and a transmitter can pace bits.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int unsigned ClksPerBit = 10
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  output logic half_o,
  output logic full_o
);

  localparam int unsigned CntW = $clog2(ClksPerBit);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign half_o = (cnt_q == CntW'(ClksPerBit / 2 - 1));
  assign full_o = (cnt_q == CntW'(ClksPerBit - 1));

  always_comb begin
    cnt_d = cnt_q + CntW'(1);
    if (clr_i || full_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: mid-bit sampling, optional parity, 1 or 2 stop
// bits, sticky error flags and a one-entry valid/ready holding register.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 50000000,
  parameter int unsigned BAUD      = 115200,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned PARITY    = 0,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  input  logic                 ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  input  logic                 err_clr,
  output logic                 busy
);

  localparam int unsigned ClksPerBit = clks_per_bit(CLK_HZ, BAUD);
  localparam int unsigned BitW       = $clog2(DATA_BITS);

  logic                 rx_meta_q, rx_s_q, rx_prev_q;
  logic [2:0]           state_q, state_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [BitW-1:0]      bitidx_q, bitidx_d;
  logic                 stopidx_q, stopidx_d;
  logic                 par_bad_q, par_bad_d;
  logic                 frm_bad_q, frm_bad_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 parity_err_q, parity_err_d;
  logic                 overrun_q, overrun_d;

  logic baud_clr, half_tick, full_tick;
  logic commit, frm_now, set_frm, set_ovr, load;

  uart_baud_tick #(
    .ClksPerBit(ClksPerBit)
  ) u_baud (
    .clk_i (clk),
    .rst_ni(rst),
    .clr_i (baud_clr),
    .half_o(half_tick),
    .full_o(full_tick)
  );

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bitidx_d  = bitidx_q;
    stopidx_d = stopidx_q;
    par_bad_d = par_bad_q;
    frm_bad_d = frm_bad_q;
    baud_clr  = 1'b0;
    commit    = 1'b0;
    case (state_q)
      StIdle: begin
        baud_clr = 1'b1;
        if (rx_prev_q && !rx_s_q) begin
          state_d   = StStart;
          bitidx_d  = '0;
          stopidx_d = 1'b0;
          par_bad_d = 1'b0;
          frm_bad_d = 1'b0;
        end
      end
      StStart: begin
        if (half_tick) begin
          if (rx_s_q) begin
            state_d = StIdle;
          end else begin
            baud_clr = 1'b1;
            state_d  = StData;
          end
        end
      end
      StData: begin
        if (full_tick) begin
          shreg_d  = {rx_s_q, shreg_q[DATA_BITS-1:1]};
          bitidx_d = bitidx_q + BitW'(1);
          if (bitidx_q == BitW'(DATA_BITS - 1)) begin
            state_d = (PARITY != PAR_NONE) ? StParity : StStop;
          end
        end
      end
      StParity: begin
        if (full_tick) begin
          par_bad_d = ((^shreg_q) ^ rx_s_q) != (PARITY == PAR_ODD);
          state_d   = StStop;
        end
      end
      StStop: begin
        if (full_tick) begin
          if (!rx_s_q) begin
            frm_bad_d = 1'b1;
          end
          stopidx_d = stopidx_q + 1'b1;
          if (stopidx_q == 1'(STOP_BITS - 1)) begin
            state_d = StIdle;
            commit  = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Commit uses the live stop sample so a low final stop bit is caught this cycle.
  always_comb begin
    frm_now = frm_bad_q | ~rx_s_q;
    set_frm = commit & frm_now;
    set_ovr = commit & ~frm_now & valid_q & ~ready;
    load    = commit & ~frm_now & ~(valid_q & ~ready);

    data_d  = data_q;
    valid_d = valid_q;
    if (load) begin
      data_d  = shreg_q;
      valid_d = 1'b1;
    end else if (valid_q && ready) begin
      valid_d = 1'b0;
    end

    frame_err_d  = set_frm | (frame_err_q & ~err_clr);
    parity_err_d = (load & par_bad_q) | (parity_err_q & ~err_clr);
    overrun_d    = set_ovr | (overrun_q & ~err_clr);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta_q    <= 1'b1;
      rx_s_q       <= 1'b1;
      rx_prev_q    <= 1'b1;
      state_q      <= StIdle;
      shreg_q      <= '0;
      bitidx_q     <= '0;
      stopidx_q    <= 1'b0;
      par_bad_q    <= 1'b0;
      frm_bad_q    <= 1'b0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      rx_meta_q    <= rx;
      rx_s_q       <= rx_meta_q;
      rx_prev_q    <= rx_s_q;
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      bitidx_q     <= bitidx_d;
      stopidx_q    <= stopidx_d;
      par_bad_q    <= par_bad_d;
      frm_bad_q    <= frm_bad_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
      overrun_q    <= overrun_d;
    end
  end

  assign data       = data_q;
  assign valid      = valid_q;
  assign frame_err  = frame_err_q;
  assign parity_err = parity_err_q;
  assign overrun    = overrun_q;
  assign busy       = (state_q != StIdle);

endmodule
